wb_gpio_ctrl: RTL

WB_GPIO_CTRL -- requirements
Module: wb_gpio_ctrl

---
 rtl/wb_gpio_pkg.sv | 52 +++++
 rtl/gpio_edge_sync.sv | 38 +++
 rtl/wb_gpio_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/wb_gpio_pkg.sv
// ============================================================================
// Module      : wb_gpio_pkg
// Description : Shared constants, encodings and helpers for wb_gpio_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_gpio_pkg;

    localparam logic [7:0] OFS_OUT      = 8'h00;
    localparam logic [7:0] OFS_OE       = 8'h04;
    localparam logic [7:0] OFS_IN       = 8'h08;
    localparam logic [7:0] OFS_EDGE_SEL = 8'h0C;
    localparam logic [7:0] OFS_IRQ_EN   = 8'h10;
    localparam logic [7:0] OFS_IRQ_STAT = 8'h14;
    localparam logic [7:0] OFS_ROUTE_LO = 8'h18;
    localparam logic [7:0] OFS_ROUTE_HI = 8'h1C;

    localparam int NCH_MIN  = 1;
    localparam int NCH_MAX  = 32;
    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 3;

    typedef enum logic [1:0] {
        ROUTE_IRQ0 = 2'd0,
        ROUTE_IRQ1 = 2'd1,
        ROUTE_IRQ2 = 2'd2,
        ROUTE_OFF  = 2'd3
    } route_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } wb_state_e;

    // Byte-lane merge of write data into an existing 32-bit register image.
    function automatic logic [31:0] wb_merge(input logic [31:0] old_v,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                r[8*b +: 8] = wdat[8*b +: 8];
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_edge_sync.sv
// ============================================================================
// Module      : gpio_edge_sync
// Description : Per-channel input synchroniser, previous-value flop and
//               selectable rising/falling edge detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic din_i,
    input  logic edge_fall_i,
    output logic sync_o,
    output logic evt_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign evt_o  = edge_fall_i ? (prev_q & ~sync_o) : (sync_o & ~prev_q);

endmodule

`default_nettype wire

// File: rtl/wb_gpio_ctrl.sv
// ============================================================================
// Module      : wb_gpio_ctrl
// Description : Wishbone-classic GPIO controller with edge interrupts routed
//               onto three level interrupt lines.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_gpio_ctrl
    import wb_gpio_pkg::*;
#(
    parameter int          NCH         = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    input  logic [3:0]      wbs_sel_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [NCH-1:0]  io_in,
    output logic [NCH-1:0]  io_out,
    output logic [NCH-1:0]  io_oeb,
    output logic [2:0]      irq
);

    localparam int ARM_CNT = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(ARM_CNT + 1);

    if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_bad_nch
        $error("wb_gpio_ctrl: NCH out of range");
    end
    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
        $error("wb_gpio_ctrl: SYNC_STAGES out of range");
    end

    wb_state_e          state_q, state_d;
    logic [NCH-1:0]     out_q,   out_d;
    logic [NCH-1:0]     oe_q,    oe_d;
    logic [NCH-1:0]     edge_q,  edge_d;
    logic [NCH-1:0]     en_q,    en_d;
    logic [NCH-1:0]     stat_q,  stat_d;
    logic [2*NCH-1:0]   route_q, route_d;
    logic [31:0]        dat_q,   dat_d;
    logic [2:0]         irq_q,   irq_d;
    logic [ARM_W-1:0]   arm_q,   arm_d;

    logic [NCH-1:0]     w_sync;
    logic [NCH-1:0]     w_evt_raw;
    logic [NCH-1:0]     w_evt;
    logic               w_armed;
    logic               w_sel;
    logic               w_go;
    logic               w_wr;
    logic [7:0]         w_ofs;
    logic [63:0]        w_route_ext;
    logic [31:0]        w_rd;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        gpio_edge_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_edge_sync (
            .clk_i       (wb_clk_i),
            .rst_ni      (wb_rst_n),
            .din_i       (io_in[i]),
            .edge_fall_i (edge_q[i]),
            .sync_o      (w_sync[i]),
            .evt_o       (w_evt_raw[i])
        );
    end

    // Synchroniser flops come out of reset at 0; hold off events until they
    // and the previous-value flop reflect the real pad levels.
    assign w_armed = (arm_q == ARM_W'(ARM_CNT));
    assign w_evt   = w_armed ? w_evt_raw : '0;
    assign arm_d   = w_armed ? arm_q : arm_q + 1'b1;

    assign w_sel       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_go        = (state_q == ST_IDLE) & w_sel;
    assign w_wr        = w_go & wbs_we_i;
    assign w_ofs       = wbs_adr_i[7:0];
    assign w_route_ext = 64'(route_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_sel) state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Events are OR-ed in after the W1C mask so a same-cycle set wins.
    always_comb begin
        out_d   = out_q;
        oe_d    = oe_q;
        edge_d  = edge_q;
        en_d    = en_q;
        route_d = route_q;
        stat_d  = stat_q | w_evt;
        if (w_wr) begin
            case (w_ofs)
                OFS_OUT:      out_d  = NCH'(wb_merge(32'(out_q),  wbs_dat_i, wbs_sel_i));
                OFS_OE:       oe_d   = NCH'(wb_merge(32'(oe_q),   wbs_dat_i, wbs_sel_i));
                OFS_EDGE_SEL: edge_d = NCH'(wb_merge(32'(edge_q), wbs_dat_i, wbs_sel_i));
                OFS_IRQ_EN:   en_d   = NCH'(wb_merge(32'(en_q),   wbs_dat_i, wbs_sel_i));
                OFS_IRQ_STAT: stat_d = (stat_q & ~NCH'(wb_merge(32'h0, wbs_dat_i, wbs_sel_i)))
                                       | w_evt;
                OFS_ROUTE_LO: route_d = (2*NCH)'({w_route_ext[63:32],
                                        wb_merge(w_route_ext[31:0], wbs_dat_i, wbs_sel_i)});
                OFS_ROUTE_HI: route_d = (2*NCH)'({wb_merge(w_route_ext[63:32], wbs_dat_i, wbs_sel_i),
                                        w_route_ext[31:0]});
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rd = 32'h0;
        case (w_ofs)
            OFS_OUT:      w_rd = 32'(out_q);
            OFS_OE:       w_rd = 32'(oe_q);
            OFS_IN:       w_rd = 32'(w_sync);
            OFS_EDGE_SEL: w_rd = 32'(edge_q);
            OFS_IRQ_EN:   w_rd = 32'(en_q);
            OFS_IRQ_STAT: w_rd = 32'(stat_q);
            OFS_ROUTE_LO: w_rd = w_route_ext[31:0];
            OFS_ROUTE_HI: w_rd = w_route_ext[63:32];
            default:      w_rd = 32'h0;
        endcase
        dat_d = (w_go & ~wbs_we_i) ? w_rd : 32'h0;
    end

    always_comb begin
        irq_d = 3'b000;
        for (int c = 0; c < NCH; c++) begin
            if (stat_q[c] & en_q[c]) begin
                case (route_q[2*c +: 2])
                    ROUTE_IRQ0: irq_d[0] = 1'b1;
                    ROUTE_IRQ1: irq_d[1] = 1'b1;
                    ROUTE_IRQ2: irq_d[2] = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            oe_q    <= '0;
            edge_q  <= '0;
            en_q    <= '0;
            stat_q  <= '0;
            route_q <= '0;
            dat_q   <= '0;
            irq_q   <= '0;
            arm_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
            edge_q  <= edge_d;
            en_q    <= en_d;
            stat_q  <= stat_d;
            route_q <= route_d;
            dat_q   <= dat_d;
            irq_q   <= irq_d;
            arm_q   <= arm_d;
        end
    end

    assign wbs_ack_o = (state_q == ST_ACK);
    assign wbs_dat_o = dat_q;
    assign io_out    = out_q;
    assign io_oeb    = ~oe_q;
    assign irq       = irq_q;

endmodule

`default_nettype wire
